mem_lane_access_ctrl: RTL and testbench
=======================================

// Module: mem_lane_access_ctrl
// PURPOSE
//  CPU-side initiator for the 4-lane byte-select data RAM (1 KW x 32, sel: 1/2/4/8=one lane, F=all).
//  Accepts LB/LBU/LH/LHU/LW/SB/SH/SW requests from the execute stage, drives the RAM addr/Din/MemWrite/sel
//  and returns aligned, sign/zero-extended load data. RAM decodes only single-lane or full-word sel,
//  so halfword and misaligned stores are sequenced as successive single-byte writes.
// PARAMETERS
//  RAM_AW  10  RAM word-address width; word addr = req_addr[RAM_AW+1:2]
//  RD_LAT  1   RAM read latency in cycles (0 = combinational q, 1 = registered q)
// PORTS
//  CLK           in   1   system clock, all state on rising edge
//  RST_N         in   1   asynchronous, active-low reset
//  req_valid     in   1   request present
//  req_ready     out  1   block idle, request accepted when valid&ready
//  req_we        in   1   1=store, 0=load
//  req_size      in   2   0=byte 1=half 2=word (3 reserved -> error)
//  req_unsigned  in   1   zero-extend load result (LBU/LHU)
//  req_addr      in   32  byte address
//  req_wdata     in   32  store data, LSB-justified
//  rsp_valid     out  1   one-cycle pulse: request complete
//  rsp_rdata     out  32  extended load data (0 for stores/errors)
//  rsp_err       out  1   valid with rsp_valid: reserved size or (no MISALIGN_EN) misaligned
//  ram_addr      out  RAM_AW  RAM word address
//  ram_din       out  32  RAM write data
//  ram_we        out  1   RAM MemWrite
//  ram_sel       out  4   RAM lane select
//  ram_dout      in   32  RAM read data
// BEHAVIOUR
//  Reset: state IDLE, req_ready=1, rsp_valid=0, rsp_rdata=0, rsp_err=0, ram_we=0, ram_sel=0, ram_addr=0, ram_din=0.
//  Mid-operation reset aborts sequence; no further ram_we pulse after RST_N falls.
//  Request latched on accept; req_ready=0 until the cycle after rsp_valid.
//  Lane n = bits[8n+7:8n], sel bit n. Byte write: sel=4'b0001<<lane, ram_din = byte replicated to all lanes.
//  SW aligned: 1 cycle, sel=F, ram_din=wdata. SB: 1 cycle. SH: 2 byte writes (lo byte then hi byte).
//  Misaligned SW: 4 byte writes, ascending byte address. Byte counter wraps lane 3->0 and increments ram_addr.
//  ram_addr[RAM_AW-1] wraps to 0 past top of RAM; no error.
//  Loads: sel=F, ram_we=0. Single word read when access fits in one word; else two reads (addr, addr+1)
//   merged as 64-bit {w1,w0} >> 8*offset, then extracted and extended per size/unsigned.
//  States: IDLE -> WR (1..4 cycles) -> RSP; IDLE -> RD0 (+RD_LAT) -> [RD1 (+RD_LAT)] -> RSP; IDLE -> RSP on error.
//  Latency accept->rsp_valid: aligned store 2, SH 3, misaligned SW 5, load 2+RD_LAT, split load 3+2*RD_LAT.
//  Error: no RAM access (ram_we=0, sel=0), rsp_err=1, rsp_rdata=0.
//  ram_we only asserted in WR state; ram_sel=0 in IDLE/RSP.
// CONFIGURATION
//  MEM_MISALIGN_EN defined: misaligned half/word split as above.
//  Undefined: half with addr[0]=1 or word with addr[1:0]!=0 -> immediate error response, RAM untouched.
// STRUCTURE
//  Package mem_access_pkg: size enum (SZ_B/SZ_H/SZ_W), state enum, SEL_ALL=4'hF, lane-select function.
//  Sub-module mem_load_align: combinational {w1,w0}+offset+size+unsigned -> 32-bit extended result.
// TESTING
//  SB 0xA5 @0x0000_0006 -> one cycle ram_we=1, sel=4'b0100, ram_addr=1, ram_din=0xA5A5A5A5; rsp 2 cycles after accept.
//  SW 0x1122_3344 @0x10 -> sel=F, ram_addr=4, din=0x11223344; LW @0x10 -> rsp_rdata=0x11223344.
//  LB @0x13 after word 0x80xxxxxx -> rsp_rdata=0xFFFFFF80; LBU -> 0x00000080; LH @0x12 over 0x8001xxxx -> 0xFFFF8001.
//  (MISALIGN_EN) SW 0xAABBCCDD @0x0F -> 4 writes: addr3 sel8 DD, addr4 sel1 CC, sel2 BB, sel4 AA; LW @0x0F -> 0xAABBCCDD.
//  (no MISALIGN_EN) LH @0x01 -> rsp_err=1, rsp_rdata=0, no RAM sel; req_size=3 -> rsp_err=1 in both builds.
//  RST_N low during 2nd byte of SH -> ram_we=0 immediately, req_ready=1 after release, next request served normally.

Source files
------------

// File: rtl/mem_access_pkg.sv
// Shared types and helpers for the lane-select data RAM access controller.
package mem_access_pkg;

    typedef enum logic [1:0] {
        SZ_B   = 2'd0,
        SZ_H   = 2'd1,
        SZ_W   = 2'd2,
        SZ_RSV = 2'd3
    } size_e;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_WR,
        ST_RD0,
        ST_RD1,
        ST_RSP
    } state_e;

    localparam logic [3:0] SEL_ALL = 4'hF;

    function automatic logic [3:0] lane_sel(input logic [1:0] lane);
        return 4'b0001 << lane;
    endfunction

    // Number of bytes minus one moved by an access of the given size.
    function automatic logic [1:0] size_bytes_m1(input size_e sz);
        case (sz)
            SZ_H:    return 2'd1;
            SZ_W:    return 2'd3;
            default: return 2'd0;
        endcase
    endfunction

endpackage

// File: rtl/mem_load_align.sv
// Purpose: extract and sign/zero-extend load data from a {w1,w0} word pair at a byte offset.
// Latency: combinational.
// Backpressure: none.
module mem_load_align
    import mem_access_pkg::*;
(
    input  logic [31:0] w1,
    input  logic [31:0] w0,
    input  logic [1:0]  offset,
    input  size_e       size,
    input  logic        is_unsigned,
    output logic [31:0] rdata
);

    logic [31:0] word;

    always_comb begin
        word  = 32'({w1, w0} >> {offset, 3'b000});
        rdata = 32'h0;
        case (size)
            SZ_B: rdata = is_unsigned ? {24'h0, word[7:0]}  : {{24{word[7]}}, word[7:0]};
            SZ_H: rdata = is_unsigned ? {16'h0, word[15:0]} : {{16{word[15]}}, word[15:0]};
            SZ_W: rdata = word;
            default: rdata = 32'h0;
        endcase
    end

endmodule

// File: rtl/mem_lane_access_ctrl.sv
// Purpose: CPU-side byte/half/word access sequencer for a 4-lane byte-select RAM (MEM_MISALIGN_EN enables split accesses).
// Latency: store 2 (SH 3, misaligned SW 5), load 2+RD_LAT (split 3+2*RD_LAT), error 1.
// Backpressure: req_ready low from accept until the cycle after rsp_valid; one request in flight.
module mem_lane_access_ctrl
    import mem_access_pkg::*;
#(
    parameter int RAM_AW = 10,
    parameter int RD_LAT = 1
)(
    input  logic              CLK,
    input  logic              RST_N,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_we,
    input  logic [1:0]        req_size,
    input  logic              req_unsigned,
    input  logic [31:0]       req_addr,
    input  logic [31:0]       req_wdata,
    output logic              rsp_valid,
    output logic [31:0]       rsp_rdata,
    output logic              rsp_err,
    output logic [RAM_AW-1:0] ram_addr,
    output logic [31:0]       ram_din,
    output logic              ram_we,
    output logic [3:0]        ram_sel,
    input  logic [31:0]       ram_dout
);

    localparam logic [7:0]        RD_LAT_C = 8'(RD_LAT);
    localparam logic [RAM_AW-1:0] ADDR_ONE = {{(RAM_AW-1){1'b0}}, 1'b1};

    state_e            state;
    size_e             sz_q;
    logic [1:0]        off_q;
    logic              uns_q;
    logic              split_q;
    logic [1:0]        wr_lane;
    logic [1:0]        wr_left;
    logic [31:0]       wr_dat;
    logic [31:0]       w0_q;
    logic [7:0]        lat_cnt;

    size_e             req_sz;
    logic [1:0]        req_off;
    logic [RAM_AW-1:0] req_waddr;
    logic              misalign;
    logic              req_err;
    logic              req_split;
    logic              accept;
    logic              rd_done;
    logic [31:0]       al_w0;
    logic [31:0]       al_w1;
    logic [31:0]       al_data;
    logic              unused_addr;

    assign req_sz      = size_e'(req_size);
    assign req_off     = req_addr[1:0];
    assign req_waddr   = req_addr[RAM_AW+1:2];
    assign unused_addr = ^req_addr[31:RAM_AW+2];
    assign accept      = req_valid & req_ready;
    assign rd_done     = (lat_cnt == RD_LAT_C);

`ifdef MEM_MISALIGN_EN
    assign misalign = 1'b0;
`else
    assign misalign = ((req_sz == SZ_H) && req_addr[0]) ||
                      ((req_sz == SZ_W) && (req_off != 2'b00));
`endif

    assign req_err   = (req_sz == SZ_RSV) || misalign;
    assign req_split = ((req_sz == SZ_H) && (req_off == 2'd3)) ||
                       ((req_sz == SZ_W) && (req_off != 2'd0));

    // In RD1 the first word is held in w0_q and the RAM is returning the second.
    assign al_w0 = (state == ST_RD1) ? w0_q : ram_dout;
    assign al_w1 = (state == ST_RD1) ? ram_dout : 32'h0;

    mem_load_align u_align (
        .w1          (al_w1),
        .w0          (al_w0),
        .offset      (off_q),
        .size        (sz_q),
        .is_unsigned (uns_q),
        .rdata       (al_data)
    );

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            state     <= ST_IDLE;
            req_ready <= 1'b1;
            rsp_valid <= 1'b0;
            rsp_rdata <= 32'h0;
            rsp_err   <= 1'b0;
            ram_addr  <= '0;
            ram_din   <= 32'h0;
            ram_we    <= 1'b0;
            ram_sel   <= 4'h0;
            sz_q      <= SZ_B;
            off_q     <= 2'd0;
            uns_q     <= 1'b0;
            split_q   <= 1'b0;
            wr_lane   <= 2'd0;
            wr_left   <= 2'd0;
            wr_dat    <= 32'h0;
            w0_q      <= 32'h0;
            lat_cnt   <= 8'd0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (accept) begin
                        req_ready <= 1'b0;
                        sz_q      <= req_sz;
                        off_q     <= req_off;
                        uns_q     <= req_unsigned;
                        split_q   <= req_split;
                        if (req_err) begin
                            state     <= ST_RSP;
                            rsp_valid <= 1'b1;
                            rsp_err   <= 1'b1;
                            rsp_rdata <= 32'h0;
                        end else if (req_we) begin
                            state    <= ST_WR;
                            ram_we   <= 1'b1;
                            ram_addr <= req_waddr;
                            wr_dat   <= req_wdata;
                            wr_lane  <= req_off;
                            if ((req_sz == SZ_W) && (req_off == 2'd0)) begin
                                ram_sel <= SEL_ALL;
                                ram_din <= req_wdata;
                                wr_left <= 2'd0;
                            end else begin
                                ram_sel <= lane_sel(req_off);
                                ram_din <= {4{req_wdata[7:0]}};
                                wr_left <= size_bytes_m1(req_sz);
                            end
                        end else begin
                            state    <= ST_RD0;
                            ram_addr <= req_waddr;
                            ram_sel  <= SEL_ALL;
                            lat_cnt  <= 8'd0;
                        end
                    end
                end
                ST_WR: begin
                    if (wr_left == 2'd0) begin
                        state     <= ST_RSP;
                        ram_we    <= 1'b0;
                        ram_sel   <= 4'h0;
                        rsp_valid <= 1'b1;
                        rsp_err   <= 1'b0;
                        rsp_rdata <= 32'h0;
                    end else begin
                        // Next byte goes to the next lane; crossing lane 3 moves to the next word.
                        wr_lane <= wr_lane + 2'd1;
                        wr_left <= wr_left - 2'd1;
                        wr_dat  <= wr_dat >> 8;
                        ram_sel <= lane_sel(wr_lane + 2'd1);
                        ram_din <= {4{wr_dat[15:8]}};
                        if (wr_lane == 2'd3) begin
                            ram_addr <= ram_addr + ADDR_ONE;
                        end
                    end
                end
                ST_RD0, ST_RD1: begin
                    if (!rd_done) begin
                        lat_cnt <= lat_cnt + 8'd1;
                    end else if ((state == ST_RD0) && split_q) begin
                        state    <= ST_RD1;
                        w0_q     <= ram_dout;
                        ram_addr <= ram_addr + ADDR_ONE;
                        lat_cnt  <= 8'd0;
                    end else begin
                        state     <= ST_RSP;
                        ram_sel   <= 4'h0;
                        rsp_valid <= 1'b1;
                        rsp_err   <= 1'b0;
                        rsp_rdata <= al_data;
                    end
                end
                ST_RSP: begin
                    state     <= ST_IDLE;
                    rsp_valid <= 1'b0;
                    rsp_err   <= 1'b0;
                    req_ready <= 1'b1;
                end
                default: begin
                    state <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mem_lane_access_ctrl.sv
// Directed bench for mem_lane_access_ctrl with a registered-output byte-lane RAM model (RD_LAT=1).
module tb_mem_lane_access_ctrl;

    logic        CLK = 1'b0;
    logic        RST_N;
    logic        req_valid;
    logic        req_ready;
    logic        req_we;
    logic [1:0]  req_size;
    logic        req_unsigned;
    logic [31:0] req_addr;
    logic [31:0] req_wdata;
    logic        rsp_valid;
    logic [31:0] rsp_rdata;
    logic        rsp_err;
    logic [9:0]  ram_addr;
    logic [31:0] ram_din;
    logic        ram_we;
    logic [3:0]  ram_sel;
    logic [31:0] ram_dout;

    always #5 CLK = ~CLK;

    mem_lane_access_ctrl #(.RAM_AW(10), .RD_LAT(1)) dut (
        .CLK          (CLK),
        .RST_N        (RST_N),
        .req_valid    (req_valid),
        .req_ready    (req_ready),
        .req_we       (req_we),
        .req_size     (req_size),
        .req_unsigned (req_unsigned),
        .req_addr     (req_addr),
        .req_wdata    (req_wdata),
        .rsp_valid    (rsp_valid),
        .rsp_rdata    (rsp_rdata),
        .rsp_err      (rsp_err),
        .ram_addr     (ram_addr),
        .ram_din      (ram_din),
        .ram_we       (ram_we),
        .ram_sel      (ram_sel),
        .ram_dout     (ram_dout)
    );

    // RAM model: byte-lane writes, registered read port.
    logic [31:0] mem [0:1023];
    logic [31:0] ram_q;
    logic        mem_clr;

    always @(posedge CLK) begin
        if (mem_clr) begin
            for (int i = 0; i < 1024; i++) mem[i] <= 32'h0;
        end else if (ram_we) begin
            for (int b = 0; b < 4; b++)
                if (ram_sel[b]) mem[ram_addr][8*b +: 8] <= ram_din[8*b +: 8];
        end
        ram_q <= mem[ram_addr];
    end
    assign ram_dout = ram_q;

    // Write and lane-select activity log, sampled mid-cycle.
    logic [9:0]  wl_addr [$];
    logic [3:0]  wl_sel  [$];
    logic [31:0] wl_din  [$];
    int          sel_cnt = 0;

    always @(negedge CLK) begin
        if (ram_we) begin
            wl_addr.push_back(ram_addr);
            wl_sel.push_back(ram_sel);
            wl_din.push_back(ram_din);
        end
        if (ram_sel != 4'h0) sel_cnt++;
    end

    int checks = 0;
    int errors = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    task automatic do_req(input string t, input logic we, input logic [1:0] sz, input logic uns,
                          input logic [31:0] addr, input logic [31:0] wd,
                          output logic [31:0] rd, output logic er, output int lat,
                          output int wbase, output int sbase);
        @(negedge CLK);
        check({t, ".ready_in"}, req_ready, 1);
        wbase        = wl_addr.size();
        sbase        = sel_cnt;
        req_valid    = 1'b1;
        req_we       = we;
        req_size     = sz;
        req_unsigned = uns;
        req_addr     = addr;
        req_wdata    = wd;
        @(posedge CLK);
        #1 req_valid = 1'b0;
        lat = 0;
        for (int k = 0; k < 20; k++) begin
            @(negedge CLK);
            lat++;
            if (rsp_valid) break;
        end
        check({t, ".rsp_seen"}, rsp_valid, 1);
        rd = rsp_rdata;
        er = rsp_err;
        @(negedge CLK);
        check({t, ".pulse"}, rsp_valid, 0);
        check({t, ".ready_out"}, req_ready, 1);
    endtask

    task automatic chk_wr(input string t, input int idx, input logic [9:0] a,
                          input logic [3:0] s, input logic [31:0] d);
        if (idx >= wl_addr.size()) begin
            check({t, ".present"}, wl_addr.size(), idx + 1);
        end else begin
            check({t, ".addr"}, {22'h0, wl_addr[idx]}, {22'h0, a});
            check({t, ".sel"},  {28'h0, wl_sel[idx]},  {28'h0, s});
            check({t, ".din"},  wl_din[idx], d);
        end
    endtask

    task automatic store(input string t, input logic [1:0] sz, input logic [31:0] addr,
                         input logic [31:0] wd, input int exp_lat, input int exp_nwr, output int wbase);
        logic [31:0] rd;
        logic        er;
        int          lat;
        int          sb;
        do_req(t, 1'b1, sz, 1'b0, addr, wd, rd, er, lat, wbase, sb);
        check({t, ".lat"}, lat, exp_lat);
        check({t, ".err"}, er, 0);
        check({t, ".rdata"}, rd, 0);
        check({t, ".nwr"}, wl_addr.size() - wbase, exp_nwr);
    endtask

    task automatic load(input string t, input logic [1:0] sz, input logic uns, input logic [31:0] addr,
                        input logic [31:0] exp_rd, input int exp_lat);
        logic [31:0] rd;
        logic        er;
        int          lat;
        int          wb;
        int          sb;
        do_req(t, 1'b0, sz, uns, addr, 32'h0, rd, er, lat, wb, sb);
        check({t, ".rdata"}, rd, exp_rd);
        check({t, ".err"}, er, 0);
        check({t, ".lat"}, lat, exp_lat);
        check({t, ".nwr"}, wl_addr.size() - wb, 0);
    endtask

    task automatic err_req(input string t, input logic we, input logic [1:0] sz, input logic [31:0] addr);
        logic [31:0] rd;
        logic        er;
        int          lat;
        int          wb;
        int          sb;
        do_req(t, we, sz, 1'b0, addr, 32'hDEADBEEF, rd, er, lat, wb, sb);
        check({t, ".err"}, er, 1);
        check({t, ".rdata"}, rd, 0);
        check({t, ".nwr"}, wl_addr.size() - wb, 0);
        check({t, ".nsel"}, sel_cnt - sb, 0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    initial begin
        int wb;
        RST_N        = 1'b0;
        mem_clr      = 1'b1;
        req_valid    = 1'b0;
        req_we       = 1'b0;
        req_size     = 2'd0;
        req_unsigned = 1'b0;
        req_addr     = 32'h0;
        req_wdata    = 32'h0;
        repeat (3) @(negedge CLK);

        check("rst.ready", req_ready, 1);
        check("rst.rsp_valid", rsp_valid, 0);
        check("rst.rdata", rsp_rdata, 0);
        check("rst.err", rsp_err, 0);
        check("rst.we", ram_we, 0);
        check("rst.sel", {28'h0, ram_sel}, 0);
        check("rst.addr", {22'h0, ram_addr}, 0);
        check("rst.din", ram_din, 0);

        RST_N   = 1'b1;
        mem_clr = 1'b0;
        @(negedge CLK);

        store("sb06", 2'd0, 32'h0000_0006, 32'h0000_00A5, 2, 1, wb);
        chk_wr("sb06.w0", wb, 10'd1, 4'b0100, 32'hA5A5_A5A5);

        store("sw10", 2'd2, 32'h0000_0010, 32'h1122_3344, 2, 1, wb);
        chk_wr("sw10.w0", wb, 10'd4, 4'hF, 32'h1122_3344);
        load("lw10", 2'd2, 1'b0, 32'h0000_0010, 32'h1122_3344, 3);

        store("sw10b", 2'd2, 32'h0000_0010, 32'h8001_7F00, 2, 1, wb);
        load("lb13",  2'd0, 1'b0, 32'h0000_0013, 32'hFFFF_FF80, 3);
        load("lbu13", 2'd0, 1'b1, 32'h0000_0013, 32'h0000_0080, 3);
        load("lh12",  2'd1, 1'b0, 32'h0000_0012, 32'hFFFF_8001, 3);
        load("lhu12", 2'd1, 1'b1, 32'h0000_0012, 32'h0000_8001, 3);
        load("lb11",  2'd0, 1'b0, 32'h0000_0011, 32'h0000_007F, 3);
        load("lb10",  2'd0, 1'b0, 32'h0000_0010, 32'h0000_0000, 3);

        store("sh22", 2'd1, 32'h0000_0022, 32'h0000_BEEF, 3, 2, wb);
        chk_wr("sh22.w0", wb,     10'd8, 4'b0100, 32'hEFEF_EFEF);
        chk_wr("sh22.w1", wb + 1, 10'd8, 4'b1000, 32'hBEBE_BEBE);
        load("lw20", 2'd2, 1'b0, 32'h0000_0020, 32'hBEEF_0000, 3);
        load("lb06", 2'd0, 1'b1, 32'h0000_0006, 32'h0000_00A5, 3);

`ifdef MEM_MISALIGN_EN
        store("sw0f", 2'd2, 32'h0000_000F, 32'hAABB_CCDD, 5, 4, wb);
        chk_wr("sw0f.w0", wb,     10'd3, 4'b1000, 32'hDDDD_DDDD);
        chk_wr("sw0f.w1", wb + 1, 10'd4, 4'b0001, 32'hCCCC_CCCC);
        chk_wr("sw0f.w2", wb + 2, 10'd4, 4'b0010, 32'hBBBB_BBBB);
        chk_wr("sw0f.w3", wb + 3, 10'd4, 4'b0100, 32'hAAAA_AAAA);
        load("lw0f", 2'd2, 1'b0, 32'h0000_000F, 32'hAABB_CCDD, 5);

        store("shfff", 2'd1, 32'h0000_0FFF, 32'h0000_5A6B, 3, 2, wb);
        chk_wr("shfff.w0", wb,     10'd1023, 4'b1000, 32'h6B6B_6B6B);
        chk_wr("shfff.w1", wb + 1, 10'd0,    4'b0001, 32'h5A5A_5A5A);
        load("lhufff", 2'd1, 1'b1, 32'h0000_0FFF, 32'h0000_5A6B, 5);
        load("lh01",   2'd1, 1'b0, 32'h0000_0001, 32'h0000_0000, 3);
`else
        err_req("lh01", 1'b0, 2'd1, 32'h0000_0001);
        err_req("sw02", 1'b1, 2'd2, 32'h0000_0002);
        load("lw10c", 2'd2, 1'b0, 32'h0000_0010, 32'h8001_7F00, 3);
`endif
        err_req("rsv_ld", 1'b0, 2'd3, 32'h0000_0040);
        err_req("rsv_st", 1'b1, 2'd3, 32'h0000_0044);

        // Reset asserted while the second byte of a halfword store is on the bus.
        @(negedge CLK);
        req_valid = 1'b1;
        req_we    = 1'b1;
        req_size  = 2'd1;
        req_addr  = 32'h0000_0030;
        req_wdata = 32'h0000_1234;
        @(posedge CLK);
        #1 req_valid = 1'b0;
        @(negedge CLK);
        check("rsth.b0_sel", {28'h0, ram_sel}, 32'h1);
        @(negedge CLK);
        check("rsth.b1_we", ram_we, 1);
        check("rsth.b1_sel", {28'h0, ram_sel}, 32'h2);
        RST_N = 1'b0;
        #1;
        check("rsth.we_off", ram_we, 0);
        check("rsth.sel_off", {28'h0, ram_sel}, 0);
        @(negedge CLK);
        RST_N = 1'b1;
        @(negedge CLK);
        check("rsth.ready", req_ready, 1);
        check("rsth.mem", mem[12], 32'h0000_0034);
        load("rsth.lw30", 2'd2, 1'b0, 32'h0000_0030, 32'h0000_0034, 3);
        store("rsth.sb31", 2'd0, 32'h0000_0031, 32'h0000_0077, 2, 1, wb);
        chk_wr("rsth.sb31.w0", wb, 10'd12, 4'b0010, 32'h7777_7777);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
